// File: rtl/uart_core_if.sv
// Stream-side bundle for uart_core: the TX word handshake and the RX FIFO
// read side. Signal names are seen from the UART: I_* enter it, O_* leave it.
interface uart_core_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] I_TX_DATA;
  logic                 I_TX_VALID;
  logic                 O_TX_READY;
  logic [DATA_BITS-1:0] O_RX_DATA;
  logic                 O_RX_VALID;
  logic                 I_RX_READY;
  logic [CNT_W-1:0]     O_RX_COUNT;

  // The UART itself
  modport slave (
    input  I_TX_DATA, I_TX_VALID, I_RX_READY,
    output O_TX_READY, O_RX_DATA, O_RX_VALID, O_RX_COUNT
  );

  // The producer/consumer driving the UART
  modport master (
    output I_TX_DATA, I_TX_VALID, I_RX_READY,
    input  O_TX_READY, O_RX_DATA, O_RX_VALID, O_RX_COUNT
  );
endinterface

// File: rtl/uart_core.sv
// UART core: shared 16x oversample tick, RX deserialiser feeding a
// first-word-fall-through FIFO, and an independent TX serialiser.
module uart_core #(
  parameter int CLK_DIV    = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          I_CLK,
  input  logic          I_RSTF,
  input  logic          I_RX,
  output logic          O_TX,
  output logic          O_PARITY_ERR,
  output logic          O_FRAME_ERR,
  output logic          O_OVERRUN,
  uart_core_if.slave    bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STP = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- tick generator ----------------
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic        tick;

  // Free-running divider; tick is the terminal count, one cycle per wrap
  always_comb begin
    tick       = (tick_cnt_q == DIV_M1);
    tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
  end

  // Divider register
  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) tick_cnt_q <= '0;
    else         tick_cnt_q <= tick_cnt_d;
  end

  // ---------------- RX synchroniser ----------------
  // rx_prev_q doubles as the "line has been high" flag: a start is only
  // seen on a 1->0 step, so a line stuck low after a framing error is ignored.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // Two-flop synchroniser plus one-cycle history for edge detection
  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= I_RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------- RX FSM ----------------
  state_t               rx_state_q, rx_state_d;
  logic [3:0]           rx_tcnt_q, rx_tcnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_bad_q, rx_par_bad_d;
  logic                 rx_stop_bad_q, rx_stop_bad_d;
  logic                 rx_push, rx_stop_low, rx_sample;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;

  // RX next state: mid-start resample at tick 8, then one sample per 16 ticks
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_tcnt_d     = rx_tcnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_par_bad_d  = rx_par_bad_q;
    rx_stop_bad_d = rx_stop_bad_q;
    rx_push       = 1'b0;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    rx_stop_low   = rx_stop_bad_q | ~rx_sync_q;
    rx_sample     = tick && (rx_tcnt_q == 4'd15);
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = S_START;
          rx_tcnt_d  = 4'd0;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_tcnt_q == 4'd7) begin
            rx_tcnt_d = 4'd0;
            if (!rx_sync_q) begin
              rx_state_d    = S_DATA;
              rx_bit_d      = 4'd0;
              rx_par_bad_d  = 1'b0;
              rx_stop_bad_d = 1'b0;
            end else begin
              rx_state_d = S_IDLE;
            end
          end else begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_sample) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 4'd1;
          if (rx_bit_q == LAST_BIT) begin
            rx_bit_d   = 4'd0;
            rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_sample) begin
          // XOR over data+parity is 1 for odd ones count
          rx_par_bad_d = (PARITY == 1) ? ~(^{rx_shift_q, rx_sync_q})
                                       :  (^{rx_shift_q, rx_sync_q});
          rx_state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_sample) begin
          if (rx_bit_q == LAST_STP) begin
            rx_bit_d   = 4'd0;
            rx_state_d = S_IDLE;
            if (rx_stop_low)       frame_err_d  = 1'b1;
            else if (rx_par_bad_q) parity_err_d = 1'b1;
            else                   rx_push      = 1'b1;
          end else begin
            rx_stop_bad_d = rx_stop_low;
            rx_bit_d      = rx_bit_q + 4'd1;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // RX state registers and registered error pulses
  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      rx_state_q    <= S_IDLE;
      rx_tcnt_q     <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_bad_q  <= 1'b0;
      rx_stop_bad_q <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_tcnt_q     <= rx_tcnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_par_bad_q  <= rx_par_bad_d;
      rx_stop_bad_q <= rx_stop_bad_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 fifo_full, push_ok, pop;

  // Fullness is judged before the same-cycle pop, so a push into a full
  // FIFO is dropped even if the consumer frees a slot in that cycle.
  always_comb begin
    fifo_full = (count_q == FULL_CNT);
    push_ok   = rx_push && !fifo_full;
    overrun_d = rx_push && fifo_full;
    pop       = (count_q != '0) && bus.I_RX_READY;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  // FIFO pointers, occupancy and overrun pulse
  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge I_CLK) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= rx_shift_q;
  end

  assign bus.O_RX_DATA  = fifo_mem_q[rd_ptr_q];
  assign bus.O_RX_VALID = (count_q != '0);
  assign bus.O_RX_COUNT = count_q;
  assign O_PARITY_ERR   = parity_err_q;
  assign O_FRAME_ERR    = frame_err_q;
  assign O_OVERRUN      = overrun_q;

  // ---------------- TX FSM ----------------
  state_t               tx_state_q, tx_state_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_bit_end;

  // TX next state: each line level is held for 16 ticks of the shared divider
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_ready_d = tx_ready_q;
    tx_bit_end = tick && (tx_tcnt_q == 4'd15);
    if (tx_state_q != S_IDLE && tick) tx_tcnt_d = tx_tcnt_q + 4'd1;
    case (tx_state_q)
      S_IDLE: begin
        if (bus.I_TX_VALID && tx_ready_q) begin
          tx_shift_d = bus.I_TX_DATA;
          tx_par_d   = (PARITY == 1) ? ~(^bus.I_TX_DATA) : (^bus.I_TX_DATA);
          tx_state_d = S_START;
          tx_tcnt_d  = 4'd0;
          tx_bit_d   = 4'd0;
          tx_d       = 1'b0;
          tx_ready_d = 1'b0;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_state_d = S_DATA;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit_q == LAST_BIT) begin
            tx_bit_d = 4'd0;
            if (PARITY != 0) begin
              tx_state_d = S_PARITY;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = S_STOP;
              tx_d       = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = S_STOP;
          tx_d       = 1'b1;
        end
      end
      S_STOP: begin
        if (tx_bit_end) begin
          if (tx_bit_q == LAST_STP) begin
            tx_state_d = S_IDLE;
            tx_bit_d   = 4'd0;
            tx_ready_d = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_d       = 1'b1;
        tx_ready_d = 1'b1;
      end
    endcase
  end

  // TX state registers; line and ready are registered outputs
  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      tx_state_q <= S_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign O_TX           = tx_q;
  assign bus.O_TX_READY = tx_ready_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core. DUT A uses defaults (TX timing, framing
// error, glitch, reset behaviour); DUT B uses a fast divider, even parity
// and a 4-deep FIFO (loopback, parity error, overrun).
module tb_uart_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rstf_a, rstf_b;
  logic rx_a_drv, rx_b_drv, loop_b;
  logic tx_a, tx_b, rx_b;
  logic perr_a, ferr_a, ovr_a, perr_b, ferr_b, ovr_b;
  int   perr_a_n = 0, ferr_a_n = 0, ovr_a_n = 0;
  int   perr_b_n = 0, ferr_b_n = 0, ovr_b_n = 0;

  uart_core_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus_a ();
  uart_core_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  bus_b ();

  assign rx_b = loop_b ? tx_b : rx_b_drv;

  uart_core dut_a (
    .I_CLK(clk), .I_RSTF(rstf_a), .I_RX(rx_a_drv), .O_TX(tx_a),
    .O_PARITY_ERR(perr_a), .O_FRAME_ERR(ferr_a), .O_OVERRUN(ovr_a), .bus(bus_a)
  );

  uart_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .I_CLK(clk), .I_RSTF(rstf_b), .I_RX(rx_b), .O_TX(tx_b),
    .O_PARITY_ERR(perr_b), .O_FRAME_ERR(ferr_b), .O_OVERRUN(ovr_b), .bus(bus_b)
  );

  // Error pulse counters
  always @(posedge clk) begin
    if (perr_a) perr_a_n <= perr_a_n + 1;
    if (ferr_a) ferr_a_n <= ferr_a_n + 1;
    if (ovr_a)  ovr_a_n  <= ovr_a_n + 1;
    if (perr_b) perr_b_n <= perr_b_n + 1;
    if (ferr_b) ferr_b_n <= ferr_b_n + 1;
    if (ovr_b)  ovr_b_n  <= ovr_b_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic drive_bit(input bit to_b, input logic v, input int clks);
    if (to_b) rx_b_drv = v;
    else      rx_a_drv = v;
    repeat (clks) @(negedge clk);
  endtask

  // start, 8 data bits LSB first, optional parity, one stop, one idle bit
  task automatic drive_frame(input bit to_b, input logic [7:0] data, input bit has_par,
                             input logic par, input logic stop, input int bclk);
    drive_bit(to_b, 1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(to_b, data[i], bclk);
    if (has_par) drive_bit(to_b, par, bclk);
    drive_bit(to_b, stop, bclk);
    drive_bit(to_b, 1'b1, bclk);
    $display("frame %s data=%02h par=%0b stop=%0b", to_b ? "B" : "A", data, par, stop);
  endtask

  task automatic pop_b(input logic [7:0] exp, input string tag);
    check(tag, {24'd0, bus_b.O_RX_DATA}, {24'd0, exp});
    bus_b.I_RX_READY = 1'b1;
    @(negedge clk);
    bus_b.I_RX_READY = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_bits;
    int n, total, base_p, base_f, base_o;

    rstf_a = 1'b0; rstf_b = 1'b0;
    rx_a_drv = 1'b1; rx_b_drv = 1'b1; loop_b = 1'b0;
    bus_a.I_TX_DATA = '0; bus_a.I_TX_VALID = 1'b0; bus_a.I_RX_READY = 1'b0;
    bus_b.I_TX_DATA = '0; bus_b.I_TX_VALID = 1'b0; bus_b.I_RX_READY = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx", tx_a, 1);
    check("rst_ready", bus_a.O_TX_READY, 1);
    check("rst_valid", bus_a.O_RX_VALID, 0);
    check("rst_count", bus_a.O_RX_COUNT, 0);
    check("rst_errs", {perr_a, ferr_a, ovr_a}, 0);
    rstf_a = 1'b1; rstf_b = 1'b1;
    repeat (5) @(negedge clk);
    $display("reset released");

    // TX 0x55 on defaults: start 0, 1,0,1,0,1,0,1,0, stop 1
    bus_a.I_TX_DATA = 8'h55; bus_a.I_TX_VALID = 1'b1;
    @(posedge clk); #1;
    check("tx_start_low", tx_a, 0);
    check("tx_ready_low", bus_a.O_TX_READY, 0);
    bus_a.I_TX_VALID = 1'b0;
    bus_a.I_TX_DATA = 8'hFF;
    exp_bits = 10'h2AA;
    total = 0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("tx_bit%0d_level", i), tx_a, exp_bits[i]);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (tx_a === exp_bits[i] && n < 1000);
      total += n;
      // start bit length depends on the free-running tick phase at accept
      if (i == 0) check_range("tx_start_len", n, 406, 432);
      else        check($sformatf("tx_bit%0d_len", i), n, 432);
    end
    check("tx_stop_level", tx_a, 1);
    n = 0;
    while (bus_a.O_TX_READY !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    total += n;
    check("tx_stop_len", n, 432);
    check_range("tx_frame_len", total, 4294, 4320);
    check("tx_idle_high", tx_a, 1);
    $display("tx 0x55 frame length %0d", total);

    // Framing error then a good frame
    @(negedge clk);
    base_f = ferr_a_n; base_p = perr_a_n;
    drive_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 432);
    repeat (5) @(negedge clk);
    check("ferr_pulse", ferr_a_n - base_f, 1);
    check("ferr_count", bus_a.O_RX_COUNT, 0);
    drive_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 432);
    repeat (5) @(negedge clk);
    check("good_count", bus_a.O_RX_COUNT, 1);
    check("good_data", bus_a.O_RX_DATA, 8'h11);
    check("good_noerr", (ferr_a_n - base_f) + (perr_a_n - base_p), 1);
    bus_a.I_RX_READY = 1'b1; @(negedge clk); bus_a.I_RX_READY = 1'b0;
    @(negedge clk);
    check("pop_count", bus_a.O_RX_COUNT, 0);

    // Glitch of 3*CLK_DIV clocks
    base_f = ferr_a_n; base_p = perr_a_n;
    drive_bit(1'b0, 1'b0, 81);
    drive_bit(1'b0, 1'b1, 432);
    check("glitch_count", bus_a.O_RX_COUNT, 0);
    check("glitch_noerr", (ferr_a_n - base_f) + (perr_a_n - base_p), 0);
    $display("glitch done");

    // Reset in the middle of a TX frame of 0x00
    bus_a.I_TX_DATA = 8'h00; bus_a.I_TX_VALID = 1'b1;
    @(negedge clk);
    bus_a.I_TX_VALID = 1'b0;
    repeat (1000) @(negedge clk);
    check("midtx_low", tx_a, 0);
    #2 rstf_a = 1'b0;
    #1;
    check("midtx_rst_high", tx_a, 1);
    check("midtx_rst_ready", bus_a.O_TX_READY, 1);
    @(negedge clk);
    rstf_a = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_tx", tx_a, 1);
    check("post_rst_count", bus_a.O_RX_COUNT, 0);
    drive_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 432);
    repeat (5) @(negedge clk);
    check("post_rst_rx_count", bus_a.O_RX_COUNT, 1);
    check("post_rst_rx_data", bus_a.O_RX_DATA, 8'h5A);

    // DUT B: loopback of 0xA3 with even parity
    base_p = perr_b_n; base_f = ferr_b_n; base_o = ovr_b_n;
    loop_b = 1'b1;
    bus_b.I_TX_DATA = 8'hA3; bus_b.I_TX_VALID = 1'b1;
    @(negedge clk);
    bus_b.I_TX_VALID = 1'b0;
    n = 0;
    while (bus_b.O_TX_READY !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    check("loop_tx_done", bus_b.O_TX_READY, 1);
    repeat (5) @(negedge clk);
    loop_b = 1'b0;
    check("loop_count", bus_b.O_RX_COUNT, 1);
    check("loop_valid", bus_b.O_RX_VALID, 1);
    check("loop_noerr", (perr_b_n - base_p) + (ferr_b_n - base_f) + (ovr_b_n - base_o), 0);
    pop_b(8'hA3, "loop_data");
    $display("loopback 0xA3 done");

    // Bad parity: 0xA3 has four ones, even parity bit should be 0
    drive_frame(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 64);
    repeat (5) @(negedge clk);
    check("perr_pulse", perr_b_n - base_p, 1);
    check("perr_valid", bus_b.O_RX_VALID, 0);

    // Overrun: five frames into a 4-deep FIFO; parity bits 1,1,0,1,0
    drive_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 64);
    drive_frame(1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 64);
    drive_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 64);
    drive_frame(1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 64);
    drive_frame(1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 64);
    repeat (5) @(negedge clk);
    check("ovr_count", bus_b.O_RX_COUNT, 4);
    check("ovr_pulse", ovr_b_n - base_o, 1);
    check("ovr_perr", perr_b_n - base_p, 1);
    pop_b(8'h01, "ovr_pop1");
    pop_b(8'h02, "ovr_pop2");
    pop_b(8'h03, "ovr_pop3");
    pop_b(8'h04, "ovr_pop4");
    check("ovr_empty", bus_b.O_RX_COUNT, 0);
    check("ovr_valid", bus_b.O_RX_VALID, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLK_DIV, default 27: system clocks per oversample tick (16 ticks per bit); legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal values 5..8.
REQ-003 Parameter PARITY, default 0: parity mode; 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 16: RX FIFO entries; power of two, 2..256.
REQ-006 I_CLK  input  1  system clock; all logic is on its rising edge.
REQ-007 I_RSTF  input  1  reset, asynchronous, active-low.
REQ-008 I_RX  input  1  serial receive line, asynchronous, idle high.
REQ-009 O_TX  output  1  serial transmit line, idle high.
REQ-010 I_TX_DATA  input  DATA_BITS  word to transmit.
REQ-011 I_TX_VALID  input  1  transmit word offered.
REQ-012 O_TX_READY  output  1  transmitter idle and able to accept a word.
REQ-013 O_RX_DATA  output  DATA_BITS  RX FIFO head word.
REQ-014 O_RX_VALID  output  1  RX FIFO not empty.
REQ-015 I_RX_READY  input  1  consumer pops head when O_RX_VALID is high.
REQ-016 O_RX_COUNT  output  clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
REQ-017 O_PARITY_ERR / O_FRAME_ERR / O_OVERRUN  output  1 each  one-cycle error pulses.

Function
REQ-018 Tick generator: counter 0..CLK_DIV-1, wraps to 0; tick asserted exactly one cycle per wrap, i.e. once every CLK_DIV clocks.
REQ-019 I_RX passes a 2-flop synchroniser before use; all RX decisions use the synchronised value.
REQ-020 RX states: IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-021 IDLE->START on synchronised high-to-low transition; on the 8th tick in START the line is resampled: low -> DATA, high -> IDLE (glitch, nothing reported).
REQ-022 DATA: one sample every 16 ticks after the mid-start sample, LSB first, DATA_BITS samples; then PARITY (one sample) then STOP (STOP_BITS samples, 16 ticks apart).
REQ-023 Any low stop sample -> O_FRAME_ERR pulse, word discarded; RX returns to IDLE, and a line still low is not taken as a new start until it has been high.
REQ-024 Parity mismatch (odd: data plus parity bit has odd count of ones; even: even count) with good stop -> O_PARITY_ERR pulse, word discarded.
REQ-025 Good word: pushed into RX FIFO in the cycle of the last stop sample; RX returns to IDLE in that cycle.
REQ-026 Push while FIFO full (evaluated before any same-cycle pop) -> word dropped, O_OVERRUN pulse, FIFO contents unchanged apart from the pop.
REQ-027 FIFO pop occurs on O_RX_VALID & I_RX_READY; O_RX_DATA updates the cycle after pop; simultaneous push and pop on a non-full FIFO leaves O_RX_COUNT unchanged.
REQ-028 O_RX_DATA is first-word-fall-through: valid in the same cycle O_RX_VALID rises; read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 TX states: IDLE, START, DATA, PARITY, STOP; O_TX_READY is high only in IDLE.
REQ-030 Accept on I_TX_VALID & O_TX_READY: data latched, O_TX_READY drops next cycle, O_TX driven low (START) next cycle.
REQ-031 Each TX bit is held for 16 ticks; order: start 0, data LSB first, parity (if enabled), STOP_BITS high bits; then IDLE, O_TX_READY high.
REQ-032 I_TX_DATA changes after acceptance have no effect on the frame in flight; I_TX_VALID is ignored outside IDLE.
REQ-033 RX and TX operate independently and concurrently; both use the shared tick.

Reset
REQ-034 While I_RSTF low: O_TX=1, O_TX_READY=1 after release, O_RX_VALID=0, O_RX_COUNT=0, all error pulses 0, both FSMs IDLE, tick counter 0, synchroniser flops 1.
REQ-035 Reset mid-frame aborts immediately (asynchronously): partial RX word lost, O_TX returns high without finishing the frame.
REQ-036 First frame after reset release behaves identically to any later frame; no residual data from FIFO appears.

Verification
REQ-037 Defaults, send 0x55 -> O_TX low one cycle after accept, then 1,0,1,0,1,0,1,0,1; each bit 432 clocks; O_TX_READY high again after 4320 clocks.
REQ-038 PARITY=2, O_TX looped to I_RX, send 0xA3 -> O_RX_DATA=0xA3, O_RX_COUNT=1, no error pulses.
REQ-039 PARITY=2, drive frame 0xA3 with parity bit 1 -> one O_PARITY_ERR pulse, O_RX_VALID stays 0.
REQ-040 Drive frame 0x3C with stop bit low -> one O_FRAME_ERR pulse, O_RX_COUNT stays 0; next valid frame 0x11 received correctly.
REQ-041 FIFO_DEPTH=4, drive 5 frames 0x01..0x05, I_RX_READY=0 -> O_RX_COUNT=4, one O_OVERRUN pulse, pops return 0x01..0x04.
REQ-042 Low pulse on I_RX of 3*CLK_DIV clocks -> no word, no error pulse; reset asserted mid-TX frame -> O_TX high within the reset assertion cycle.
